match_event_counter: RTL and testbench
======================================

Name: match_event_counter

Overview:
- Downstream stage of the serial sequence detector.
- Consumes the detector's one-bit match flag z, registered in the same Clock domain.
- Counts distinct match events (rising edges of z), tracks current and longest match-run length, emits a one-cycle strobe per new match, and drives four active-low 7-segment displays for board inspection.

Parameters:
- CNT_W, 8, width of the match-event counter (saturating).
- RUN_W, 4, width of the run-length and max-run registers (saturating).

Ports:
- Clock  input  1  system clock; all state updates on posedge.
- Resetn  input  1  synchronous, active-low reset, sampled on posedge Clock.
- z  input  1  match flag from the detector, synchronous to Clock.
- Clear  input  1  synchronous statistics clear, active-high.
- Hold  input  1  freeze: when 1, no register changes except under reset.
- match_pulse  output  1  one-cycle strobe for each new match event.
- count  output  CNT_W  number of match events since reset/clear.
- run_len  output  RUN_W  cycles z has been high in the current run.
- max_run  output  RUN_W  longest run_len seen since reset/clear.
- HEX0  output  7  count[3:0] hex digit, active-low segments.
- HEX1  output  7  count[7:4] hex digit, active-low segments.
- HEX2  output  7  max_run hex digit, active-low segments.
- HEX3  output  7  run_len hex digit, active-low segments.

Behaviour:
- One clock, one reset; reset is synchronous and active-low, named Resetn; clock named Clock.
- Reset (Resetn=0 at posedge):
  - state <= IDLE.
  - count, run_len, max_run, match_pulse <= 0.
  - Reset overrides Clear and Hold.
- Two-state FSM, transitions evaluated each posedge when Hold=0:
  - IDLE, z=0: stay IDLE; run_len held at 0.
  - IDLE, z=1: go to MATCH; count <= count+1 (saturate at all-ones); run_len <= 1; match_pulse <= 1 for exactly the next cycle.
  - MATCH, z=1: stay MATCH; run_len <= run_len+1, saturating at 2^RUN_W-1; no count change; match_pulse <= 0.
  - MATCH, z=0: go to IDLE; run_len <= 0; match_pulse <= 0.
- max_run update: each non-held cycle, max_run <= max(max_run, next run_len). Value is therefore current within the same cycle run_len grows.
- Latency: z rising at edge k increments count and raises match_pulse visible after edge k; one-cycle registered latency.
- Saturation: count at 255 stays 255 on further events; match_pulse still fires. run_len at 15 stays 15 while z remains high.
- Clear=1 (Resetn=1, Hold=0):
  - count, run_len, max_run <= 0; match_pulse <= 0.
  - State still follows z: an IDLE->MATCH edge during Clear is not counted and does not pulse.
  - A run in progress continues in MATCH with run_len restarting from 0 on the next non-cleared cycle: run_len <= 1 after the first cycle of z=1 following Clear.
- Hold=1 (Resetn=1):
  - All registers, including state and match_pulse, keep their values.
  - z edges occurring only during Hold are lost by design.
  - Hold has priority over Clear.
- HEX outputs:
  - Combinational from registers; standard active-low hex decode (0=1000000, 1=1111001, ... F=0001110).
  - After reset all four show "0".
- No X propagation: all registers are reset, with a default FSM branch to IDLE.

Test Plan:
- Reset, then z=0 for 5 cycles -> count=0, run_len=0, max_run=0, match_pulse never 1, HEX0..3=1000000.
- z pattern 0,1,1,1,0,1,0 -> match_pulse high 2 single cycles; count=2; run_len sequence 0,1,2,3,0,1,0; max_run=3; HEX0=0100100 ("2").
- z high 20 consecutive cycles -> run_len saturates at 15; max_run=15; count=1; exactly one match_pulse; HEX2=0001110 ("F").
- 260 isolated pulses on z (1,0 repeated) -> count stops at 255; match_pulse still asserted 260 times; HEX1=HEX0=0001110.
- Clear asserted on the same cycle z rises, then z stays high 2 more cycles -> no pulse, count=0, run_len=2, max_run=2. Then z=0,1 -> count=1.
- Hold=1 while z toggles 0,1,0, then Hold=0 -> all outputs unchanged across the hold window. Resetn=0 mid-run (run_len=4) -> next cycle all outputs 0, state IDLE.

Source files
------------

// File: rtl/match_event_counter_if.sv
// Bundles the detector-side inputs and the statistics/display outputs of the
// match event counter so the testbench and the counter share one port list.
interface match_event_counter_if #(
    parameter int CNT_W = 8,
    parameter int RUN_W = 4
);
    logic             z;
    logic             Clear;
    logic             Hold;
    logic             match_pulse;
    logic [CNT_W-1:0] count;
    logic [RUN_W-1:0] run_len;
    logic [RUN_W-1:0] max_run;
    logic [6:0]       HEX0;
    logic [6:0]       HEX1;
    logic [6:0]       HEX2;
    logic [6:0]       HEX3;

    modport master (
        output z, Clear, Hold,
        input  match_pulse, count, run_len, max_run, HEX0, HEX1, HEX2, HEX3
    );

    modport slave (
        input  z, Clear, Hold,
        output match_pulse, count, run_len, max_run, HEX0, HEX1, HEX2, HEX3
    );
endinterface

// File: rtl/match_event_counter.sv
// Counts rising edges of the detector match flag, tracks current and longest
// run length, strobes once per new match and drives four 7-segment digits.
module match_event_counter #(
    parameter int CNT_W = 8,
    parameter int RUN_W = 4
) (
    input  logic                 Clock,
    input  logic                 Resetn,
    match_event_counter_if.slave bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        MATCH = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
    localparam logic [RUN_W-1:0] RunMax = '1;
    localparam logic [RUN_W-1:0] RunOne = RUN_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [RUN_W-1:0] max_q, max_d;
    logic             pulse_q, pulse_d;

    // Active-low segment pattern, bit 6 = segment g, bit 0 = segment a.
    function automatic logic [6:0] hexSeg(input logic [3:0] value);
        logic [6:0] seg;
        case (value)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        run_d   = run_q;
        max_d   = max_q;
        pulse_d = pulse_q;

        if (!bus.Hold) begin
            pulse_d = 1'b0;
            case (state_q)
                IDLE: begin
                    run_d = '0;
                    if (bus.z) begin
                        state_d = MATCH;
                        run_d   = RunOne;
                        pulse_d = 1'b1;
                        count_d = (count_q == CntMax) ? count_q : count_q + CntOne;
                    end
                end
                MATCH: begin
                    if (bus.z) begin
                        run_d = (run_q == RunMax) ? run_q : run_q + RunOne;
                    end else begin
                        state_d = IDLE;
                        run_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    run_d   = '0;
                end
            endcase

            // Clear wipes statistics but lets the FSM keep tracking z, so a
            // run that straddles Clear restarts its length from zero.
            if (bus.Clear) begin
                count_d = '0;
                run_d   = '0;
                max_d   = '0;
                pulse_d = 1'b0;
            end else if (run_d > max_q) begin
                max_d = run_d;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q <= IDLE;
            count_q <= '0;
            run_q   <= '0;
            max_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            run_q   <= run_d;
            max_q   <= max_d;
            pulse_q <= pulse_d;
        end
    end

    assign bus.match_pulse = pulse_q;
    assign bus.count       = count_q;
    assign bus.run_len     = run_q;
    assign bus.max_run     = max_q;
    assign bus.HEX0        = hexSeg(count_q[3:0]);
    assign bus.HEX1        = hexSeg(count_q[7:4]);
    assign bus.HEX2        = hexSeg(max_q[3:0]);
    assign bus.HEX3        = hexSeg(run_q[3:0]);

endmodule

// File: tb/tb_match_event_counter.sv
// Directed bench for match_event_counter: a vector table for the single-cycle
// behaviour plus hand-written saturation sequences.
module tb_match_event_counter;

    logic Clock = 1'b0;
    logic Resetn;

    match_event_counter_if #(.CNT_W(8), .RUN_W(4)) bus ();

    match_event_counter #(.CNT_W(8), .RUN_W(4)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .bus    (bus.slave)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic       rstn;
        logic       z;
        logic       clr;
        logic       hold;
        logic       pulse;
        logic [7:0] cnt;
        logic [3:0] run;
        logic [3:0] mx;
    } vec_t;

    vec_t        vecs[$];
    logic [6:0]  segTable[16];
    int          checks = 0;
    int          errors = 0;
    int          pulseCount;

    task automatic checkField(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Drive inputs just after a rising edge, then let one rising edge act on them.
    task automatic applyStimulus(input logic rstn, input logic z, input logic clr, input logic hold);
        Resetn    = rstn;
        bus.z     = z;
        bus.Clear = clr;
        bus.Hold  = hold;
        @(posedge Clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic pulse, input logic [7:0] cnt,
                               input logic [3:0] run, input logic [3:0] mx);
        checkField({tag, " match_pulse"}, {7'b0, bus.match_pulse}, {7'b0, pulse});
        checkField({tag, " count"}, bus.count, cnt);
        checkField({tag, " run_len"}, {4'b0, bus.run_len}, {4'b0, run});
        checkField({tag, " max_run"}, {4'b0, bus.max_run}, {4'b0, mx});
        checkField({tag, " HEX0"}, {1'b0, bus.HEX0}, {1'b0, segTable[cnt[3:0]]});
        checkField({tag, " HEX1"}, {1'b0, bus.HEX1}, {1'b0, segTable[cnt[7:4]]});
        checkField({tag, " HEX2"}, {1'b0, bus.HEX2}, {1'b0, segTable[mx]});
        checkField({tag, " HEX3"}, {1'b0, bus.HEX3}, {1'b0, segTable[run]});
    endtask

    function automatic vec_t mk(input logic rstn, input logic z, input logic clr, input logic hold,
                                input logic pulse, input logic [7:0] cnt,
                                input logic [3:0] run, input logic [3:0] mx);
        vec_t v;
        v.rstn = rstn; v.z = z; v.clr = clr; v.hold = hold;
        v.pulse = pulse; v.cnt = cnt; v.run = run; v.mx = mx;
        return v;
    endfunction

    initial begin
        segTable = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                     7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                     7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                     7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

        //                rstn z  clr hold pulse cnt run max
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 5; i++) vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
        // z pattern 0,1,1,1,0,1,0
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 1, 1, 1, 1));
        vecs.push_back(mk(1, 1, 0, 0, 0, 1, 2, 2));
        vecs.push_back(mk(1, 1, 0, 0, 0, 1, 3, 3));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 3));
        vecs.push_back(mk(1, 1, 0, 0, 1, 2, 1, 3));
        vecs.push_back(mk(1, 0, 0, 0, 0, 2, 0, 3));
        // Clear on the rising edge of z, run continues from zero
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1, 1));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 2, 2));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 2));
        vecs.push_back(mk(1, 1, 0, 0, 1, 1, 1, 2));
        // Hold freezes everything, including the strobe and the FSM state
        vecs.push_back(mk(1, 0, 0, 1, 1, 1, 1, 2));
        vecs.push_back(mk(1, 1, 0, 1, 1, 1, 1, 2));
        vecs.push_back(mk(1, 0, 1, 1, 1, 1, 1, 2));
        vecs.push_back(mk(1, 1, 0, 0, 0, 1, 2, 2));
        vecs.push_back(mk(1, 1, 0, 0, 0, 1, 3, 3));
        vecs.push_back(mk(1, 1, 0, 0, 0, 1, 4, 4));
        // Reset mid-run, overriding Clear and Hold, then a fresh edge counts
        vecs.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 1, 1, 1, 1));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0));

        Resetn    = 1'b0;
        bus.z     = 1'b0;
        bus.Clear = 1'b0;
        bus.Hold  = 1'b0;
        @(posedge Clock);
        #1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rstn, vecs[i].z, vecs[i].clr, vecs[i].hold);
            checkOutput($sformatf("vec%0d", i), vecs[i].pulse, vecs[i].cnt, vecs[i].run, vecs[i].mx);
        end

        // Twenty-cycle run: run_len saturates at 15, single strobe
        applyStimulus(0, 0, 0, 0);
        pulseCount = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1, 1, 0, 0);
            pulseCount += int'(bus.match_pulse);
            checkField($sformatf("longrun%0d run_len", i), {4'b0, bus.run_len},
                       (i + 1 > 15) ? 8'd15 : 8'(i + 1));
        end
        checkOutput("longrun end", 0, 1, 15, 15);
        checkField("longrun pulses", 8'(pulseCount), 8'd1);

        // 260 isolated events: count saturates at 255, strobe keeps firing
        applyStimulus(0, 0, 0, 0);
        pulseCount = 0;
        for (int i = 0; i < 260; i++) begin
            applyStimulus(1, 1, 0, 0);
            pulseCount += int'(bus.match_pulse);
            checkField($sformatf("sat%0d count", i), bus.count, (i + 1 > 255) ? 8'd255 : 8'(i + 1));
            applyStimulus(1, 0, 0, 0);
        end
        checkOutput("sat end", 0, 8'd255, 0, 1);
        checkField("sat pulses", 8'(pulseCount - 4), 8'd0);
        checks++;
        if (pulseCount != 260) begin
            errors++;
            $display("[TB] FAIL sat pulse total: got %0d, expected 260", pulseCount);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
